// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: one valid/ready link carrying a PC and an instruction word.
// master drives valid/pc/inst and samples ready; slave is the receiving side.
interface pipe_stage_reg_if #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32
);
    logic              valid;
    logic              ready;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;

    modport master (
        output valid,
        output pc,
        output inst,
        input  ready
    );

    modport slave (
        input  valid,
        input  pc,
        input  inst,
        output ready
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline-stage register with a two-entry skid buffer.
// The main register drives the downstream link. The skid register absorbs the one
// entry that can arrive after downstream stalls, so upstream ready is purely registered.
// Optional feature: define PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_stage_reg #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
`ifdef PIPE_STALL_CNT_EN
    output logic [CNT_W-1:0]   stall_cnt,
`endif
    pipe_stage_reg_if.slave    up,
    pipe_stage_reg_if.master   dn
);

    logic              m_valid_q, m_valid_d;
    logic [PC_W-1:0]   m_pc_q, m_pc_d;
    logic [INST_W-1:0] m_inst_q, m_inst_d;
    logic              s_valid_q, s_valid_d;
    logic [PC_W-1:0]   s_pc_q, s_pc_d;
    logic [INST_W-1:0] s_inst_q, s_inst_d;

    logic accept_in;
    logic accept_out;
    logic reload;

    assign accept_in  = up.valid && !s_valid_q;
    assign accept_out = m_valid_q && dn.ready;
    assign reload     = !m_valid_q || accept_out;

    // in_ready depends only on skid occupancy, never on downstream ready.
    assign up.ready = !s_valid_q;
    assign dn.valid = m_valid_q;
    assign dn.pc    = m_pc_q;
    assign dn.inst  = m_inst_q;

    // Next-state for main and skid slots; empty slots always hold zero data.
    always_comb begin
        m_valid_d = m_valid_q;
        m_pc_d    = m_pc_q;
        m_inst_d  = m_inst_q;
        s_valid_d = s_valid_q;
        s_pc_d    = s_pc_q;
        s_inst_d  = s_inst_q;
        if (flush) begin
            m_valid_d = 1'b0;
            m_pc_d    = '0;
            m_inst_d  = '0;
            s_valid_d = 1'b0;
            s_pc_d    = '0;
            s_inst_d  = '0;
        end else if (reload) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_pc_d    = s_pc_q;
                m_inst_d  = s_inst_q;
                // accept_in is false here since in_ready = !s_valid.
                s_valid_d = 1'b0;
                s_pc_d    = '0;
                s_inst_d  = '0;
            end else if (accept_in) begin
                m_valid_d = 1'b1;
                m_pc_d    = up.pc;
                m_inst_d  = up.inst;
            end else begin
                m_valid_d = 1'b0;
                m_pc_d    = '0;
                m_inst_d  = '0;
            end
        end else if (accept_in) begin
            s_valid_d = 1'b1;
            s_pc_d    = up.pc;
            s_inst_d  = up.inst;
        end
    end

    // Slot registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_valid_q <= 1'b0;
            m_pc_q    <= '0;
            m_inst_q  <= '0;
            s_valid_q <= 1'b0;
            s_pc_q    <= '0;
            s_inst_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_pc_q    <= m_pc_d;
            m_inst_q  <= m_inst_d;
            s_valid_q <= s_valid_d;
            s_pc_q    <= s_pc_d;
            s_inst_q  <= s_inst_d;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    assign stall_cnt = stall_cnt_q;

    // Count back-pressured cycles, saturating; flush does not clear it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid_q && !dn.ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg (stall counter section built
// only when PIPE_STALL_CNT_EN is defined, with CNT_W=2).
module tb_pipe_stage_reg;

    logic clk;
    logic rst;
    logic flush;
    int   total;
    int   bad;

    pipe_stage_reg_if #(.PC_W(32), .INST_W(32)) up_if ();
    pipe_stage_reg_if #(.PC_W(32), .INST_W(32)) dn_if ();

`ifdef PIPE_STALL_CNT_EN
    logic [1:0] stall_cnt;

    pipe_stage_reg #(.PC_W(32), .INST_W(32), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall_cnt (stall_cnt),
        .up        (up_if.slave),
        .dn        (dn_if.master)
    );
`else
    pipe_stage_reg #(.PC_W(32), .INST_W(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .up    (up_if.slave),
        .dn    (dn_if.master)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        up_if.valid = v;
        up_if.pc    = pc;
        up_if.inst  = inst;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] inst);
        check({tag, "_valid"}, {63'd0, dn_if.valid}, {63'd0, v});
        check({tag, "_pc"}, {32'd0, dn_if.pc}, {32'd0, pc});
        check({tag, "_inst"}, {32'd0, dn_if.inst}, {32'd0, inst});
    endtask

    task automatic check_rdy(input string tag, input logic r);
        check({tag, "_in_ready"}, {63'd0, up_if.ready}, {63'd0, r});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        flush = 1'b0;
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h100, 32'h2008_0100);

        // Reset held two cycles with input offered: nothing gets captured.
        step();
        step();
        check_out("rst_hold", 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        step();
        check_out("rst_rel", 1'b0, 32'h0, 32'h0);
        check_rdy("rst_rel", 1'b1);

        // Streaming with out_ready=1: one cycle latency, no bubbles.
        dn_if.ready = 1'b1;
        drive(1'b1, 32'h0, 32'h2008_0001);
        step();
        check_out("str0", 1'b1, 32'h0, 32'h2008_0001);
        check_rdy("str0", 1'b1);
        drive(1'b1, 32'h4, 32'h2008_0002);
        step();
        check_out("str1", 1'b1, 32'h4, 32'h2008_0002);
        drive(1'b1, 32'h8, 32'h2008_0003);
        step();
        check_out("str2", 1'b1, 32'h8, 32'h2008_0003);
        check_rdy("str2", 1'b1);
        drive(1'b0, 32'h0, 32'h0);
        step();
        check_out("str_idle", 1'b0, 32'h0, 32'h0);

        // Back-pressure: 0x14 lands in skid, 0x18 held upstream, then drained in order.
        drive(1'b1, 32'h10, 32'h2008_0010);
        step();
        check_out("bp0", 1'b1, 32'h10, 32'h2008_0010);
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h14, 32'h2008_0014);
        step();
        check_out("bp_skid", 1'b1, 32'h10, 32'h2008_0010);
        check_rdy("bp_skid", 1'b0);
        drive(1'b1, 32'h18, 32'h2008_0018);
        step();
        check_out("bp_hold", 1'b1, 32'h10, 32'h2008_0010);
        check_rdy("bp_hold", 1'b0);
        dn_if.ready = 1'b1;
        step();
        check_out("bp_rel1", 1'b1, 32'h14, 32'h2008_0014);
        check_rdy("bp_rel1", 1'b1);
        step();
        check_out("bp_rel2", 1'b1, 32'h18, 32'h2008_0018);
        drive(1'b0, 32'h0, 32'h0);
        step();
        check_out("bp_idle", 1'b0, 32'h0, 32'h0);

        // Flush with main=0x20, skid=0x24 and 0x28 offered.
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h20, 32'h2008_0020);
        step();
        drive(1'b1, 32'h24, 32'h2008_0024);
        step();
        check_out("fl_pre", 1'b1, 32'h20, 32'h2008_0020);
        check_rdy("fl_pre", 1'b0);
        drive(1'b1, 32'h28, 32'h2008_0028);
        flush = 1'b1;
        step();
        check_out("fl_post", 1'b0, 32'h0, 32'h0);
        check_rdy("fl_post", 1'b1);
        // Input accepted during a flush on an empty stage is discarded too.
        drive(1'b1, 32'h2c, 32'h2008_002c);
        step();
        check_out("fl_empty", 1'b0, 32'h0, 32'h0);
        flush = 1'b0;
        dn_if.ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        step();
        check_out("fl_drain", 1'b0, 32'h0, 32'h0);

        // Reset mid-transfer drops both held entries.
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h30, 32'h2008_0030);
        step();
        drive(1'b1, 32'h34, 32'h2008_0034);
        step();
        check_rdy("mid_full", 1'b0);
        drive(1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_out("mid_rst", 1'b0, 32'h0, 32'h0);
        check_rdy("mid_rst", 1'b1);
        dn_if.ready = 1'b1;
        step();
        check_out("mid_after", 1'b0, 32'h0, 32'h0);

`ifdef PIPE_STALL_CNT_EN
        // Stall counter, CNT_W=2: counts 1,2,3 then saturates; flush keeps it.
        check("sc_reset", {62'd0, stall_cnt}, 64'd0);
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h40, 32'h2008_0040);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("sc_load", {62'd0, stall_cnt}, 64'd0);
        step();
        check("sc_1", {62'd0, stall_cnt}, 64'd1);
        step();
        check("sc_2", {62'd0, stall_cnt}, 64'd2);
        step();
        check("sc_3", {62'd0, stall_cnt}, 64'd3);
        step();
        check("sc_sat4", {62'd0, stall_cnt}, 64'd3);
        step();
        check("sc_sat5", {62'd0, stall_cnt}, 64'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("sc_flush", {62'd0, stall_cnt}, 64'd3);
        check_out("sc_flush", 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("sc_rst", {62'd0, stall_cnt}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline-stage register: the next-generation replacement for fixed inter-stage latches (IF/ID first, then ID/EX onward). Carries a PC and an instruction word with a valid/ready handshake, a two-entry skid buffer for full throughput with a registered upstream ready, and a synchronous flush for branch/exception squash. Sits between any two adjacent stages of the MIPS32 core.

## Interface
- PC_W, default 32: PC field width.
- INST_W, default 32: instruction field width.
- CNT_W, default 16: stall-counter width (used only with PIPE_STALL_CNT_EN).

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- flush  in  1  squash all held entries this cycle.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept; driven only from state (no combinational path from out_ready).
- in_pc  in  PC_W  upstream PC.
- in_inst  in  INST_W  upstream instruction.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  presented PC.
- out_inst  out  INST_W  presented instruction.
- stall_cnt  out  CNT_W  downstream back-pressure cycle count (present only with PIPE_STALL_CNT_EN).

## Operation
- Storage: main register (m_valid, m_pc, m_inst) drives the outputs; skid register (s_valid, s_pc, s_inst) holds one overflow entry.
- in_ready = !s_valid. out_valid = m_valid. out_pc/out_inst = main data.
- Accept-in: in_valid && in_ready. Accept-out: out_valid && out_ready.
- Main reload condition: !m_valid || accept-out.
  - reload and s_valid: main <- skid; skid <- input if accept-in, else s_valid <- 0.
  - reload and !s_valid: main <- input if accept-in, else m_valid <- 0.
  - no reload and accept-in: skid <- input, s_valid <- 1.
- Order strictly FIFO; no entry is duplicated or dropped except by flush/reset.
- Invalid slots hold data zero (m_pc/m_inst zeroed when m_valid goes 0), so an idle stage presents a NOP (0x00000000).
- Flush: m_valid <- 0, s_valid <- 0, all data <- 0; any input accepted in the same cycle is discarded. Accept-out in the flush cycle still counts as delivered downstream.
- Priority: rst > flush > handshake.

## Timing
- Reset (rst==0 at edge): m_valid=0, s_valid=0, out_pc=0, out_inst=0, out_valid=0, in_ready=1 from the next cycle, stall_cnt=0.
- Latency: entry accepted at edge N is on out_* after edge N (one cycle), if main was empty or drained at N.
- Throughput: one entry per cycle while out_ready stays 1.
- Back-pressure: after out_ready falls, at most one further entry is accepted (into skid); in_ready drops the cycle after.
- Recovery: when out_ready rises with skid full, skid entry moves to main at that edge; in_ready returns to 1 the following cycle.
- Flush with rst==0 in same cycle: reset wins (identical end state).
- Reset mid-transfer: all held entries lost, no partial output.

## Configuration
- PIPE_STALL_CNT_EN defined: stall_cnt port exists; increments by 1 on every edge with out_valid && !out_ready, saturates at 2^CNT_W-1, cleared only by rst (not flush).
- Undefined: stall_cnt port and counter logic absent; handshake behaviour identical.

## Test plan
- Reset: drive rst=0 two cycles with in_valid=1, in_pc=0x100 -> out_valid=0, out_pc=0, out_inst=0, in_ready=1 after release.
- Streaming: out_ready=1, send pc 0x0,0x4,0x8 inst 0x20080001.. on consecutive cycles -> same sequence on out_* one cycle later, no bubbles.
- Back-pressure: stream 0x10,0x14,0x18, hold out_ready=0 after 0x10 appears -> 0x14 in skid, in_ready=0, 0x18 held upstream; release -> 0x10,0x14,0x18 in order, none lost.
- Flush: main=0x20, skid=0x24, flush=1 with in_valid=1 pc 0x28 -> next cycle out_valid=0, out_pc=0, in_ready=1; 0x28 not delivered.
- Stall counter (macro on, CNT_W=2): hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt 1,2,3,3,3; flush leaves 3; rst clears to 0.
- Macro off: same streaming test passes; no stall_cnt port elaborated.
